polyveck_power2round_stream: RTL and testbench

- Pipelined, handshaked Power2Round over a K-polynomial vector, LANES coefficients per beat.
- Replaces the flat all-combinational vector form: area scales with LANES, not K*N.
- Sits between the t = A*s1 + s2 accumulator and the t1 packer / t0 store in key generation.
- Tracks polynomial/beat position, optionally normalises negative inputs (caddq), flags out-of-range coefficients.

---
 rtl/dilithium_pkg.sv | 22 ++
 rtl/power2round_lane.sv | 54 +++++
 rtl/polyveck_power2round_stream.sv | 175 +++++++++++++++++
 tb/tb_polyveck_power2round_stream.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dilithium_pkg.sv
// -----------------------------------------------------------------------------
// dilithium_pkg
// Shared constants for the Dilithium key-generation datapath: modulus Q,
// dropped-bit count D, polynomial length N, coefficient width and the default
// number of coefficient lanes per stream beat. Also provides a clog2 helper
// that never returns zero, so single-entry counters still get a 1-bit field.
// No ports (package).
// -----------------------------------------------------------------------------
package dilithium_pkg;

    localparam int DIL_Q     = 8380417;
    localparam int DIL_D     = 13;
    localparam int DIL_N     = 256;
    localparam int COEFF_W   = 32;
    localparam int DIL_LANES = 8;

    // Width of a counter/index able to hold 0..v-1, at least one bit wide.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/power2round_lane.sv
// -----------------------------------------------------------------------------
// power2round_lane
// Purely combinational Power2Round for one coefficient, split into two
// independent halves so the parent can put a pipeline register between them.
//   Sum half (fed from the stream input):
//     a    in   raw signed coefficient
//     ap   out  a' = a + Q when CADDQ_EN and a < 0, else a
//     sum  out  a' + 2^(D-1) - 1 (rounding sum)
//     err  out  a' outside [0, Q)
//   Shift/subtract half (fed from the registered sum-half results):
//     ap_q  in   registered a'
//     sum_q in   registered rounding sum
//     a1    out  sum_q >>> D
//     a0    out  ap_q - (a1 << D)
// -----------------------------------------------------------------------------
module power2round_lane
    import dilithium_pkg::*;
#(
    parameter int D        = DIL_D,
    parameter int Q        = DIL_Q,
    parameter int CADDQ_EN = 1
) (
    input  logic [COEFF_W-1:0] a,
    output logic [COEFF_W-1:0] ap,
    output logic [COEFF_W-1:0] sum,
    output logic               err,
    input  logic [COEFF_W-1:0] ap_q,
    input  logic [COEFF_W-1:0] sum_q,
    output logic [COEFF_W-1:0] a1,
    output logic [COEFF_W-1:0] a0
);

    localparam logic signed [COEFF_W-1:0] QS  = COEFF_W'(Q);
    localparam logic signed [COEFF_W-1:0] RND = COEFF_W'((1 << (D - 1)) - 1);

    logic signed [COEFF_W-1:0] a_s;
    logic signed [COEFF_W-1:0] ap_s;
    logic signed [COEFF_W-1:0] a1_s;

    always_comb begin
        a_s  = $signed(a);
        ap_s = ((CADDQ_EN != 0) && (a_s < 0)) ? (a_s + QS) : a_s;
        ap   = ap_s;
        sum  = ap_s + RND;
        // The range flag is informational; a1/a0 are produced regardless.
        err  = (ap_s < 0) || (ap_s >= QS);

        // Arithmetic shift keeps negative a' (CADDQ_EN=0) rounding correctly.
        a1_s = $signed(sum_q) >>> D;
        a1   = a1_s;
        a0   = ap_q - (a1_s << D);
    end

endmodule

// File: rtl/polyveck_power2round_stream.sv
// -----------------------------------------------------------------------------
// polyveck_power2round_stream
// Streaming Power2Round over a vector of K polynomials, LANES coefficients per
// beat, two register stages (sum stage, shift/subtract stage), valid/ready on
// both sides, 1 beat/cycle with no stall.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  input handshake; in_ready = !s1_valid | stage 2 advances
//   in_data         LANES signed 32-bit coefficients, lane i at [32i+31:32i]
//   out_valid/ready output handshake; outputs hold while stalled
//   out_a1, out_a0  per-lane high / low parts, same lane order
//   out_poly        polynomial index of the output beat
//   out_last_poly   final beat of the current polynomial
//   out_last        final beat of the vector
//   out_range_err   some lane of this beat had a' outside [0, Q)
//   busy            a vector has started and its out_last is not yet accepted
// -----------------------------------------------------------------------------
module polyveck_power2round_stream
    import dilithium_pkg::*;
#(
    parameter int K        = 6,
    parameter int N        = DIL_N,
    parameter int LANES    = DIL_LANES,
    parameter int D        = DIL_D,
    parameter int Q        = DIL_Q,
    parameter int CADDQ_EN = 1,
    localparam int PW      = clog2_min1(K),
    localparam int DW      = COEFF_W * LANES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_a1,
    output logic [DW-1:0] out_a0,
    output logic [PW-1:0] out_poly,
    output logic          out_last_poly,
    output logic          out_last,
    output logic          out_range_err,
    output logic          busy
);

    localparam int NB = N / LANES;
    localparam int BW = clog2_min1(NB);

    // Input-side position counters
    logic [BW-1:0] beat_reg;
    logic [PW-1:0] poly_reg;

    // Stage 1: a', rounding sum, lane errors and position tags
    logic             s1_valid_reg;
    logic [DW-1:0]    s1_ap_reg;
    logic [DW-1:0]    s1_sum_reg;
    logic [LANES-1:0] s1_err_reg;
    logic [PW-1:0]    s1_poly_reg;
    logic             s1_last_poly_reg;
    logic             s1_last_reg;

    logic busy_reg;

    // Combinational lane results
    logic [DW-1:0]    lane_ap;
    logic [DW-1:0]    lane_sum;
    logic [LANES-1:0] lane_err;
    logic [DW-1:0]    lane_a1;
    logic [DW-1:0]    lane_a0;

    logic s2_adv;
    logic in_fire;
    logic beat_last;
    logic poly_last;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            power2round_lane #(
                .D        (D),
                .Q        (Q),
                .CADDQ_EN (CADDQ_EN)
            ) u_lane (
                .a     (in_data[COEFF_W*gi +: COEFF_W]),
                .ap    (lane_ap[COEFF_W*gi +: COEFF_W]),
                .sum   (lane_sum[COEFF_W*gi +: COEFF_W]),
                .err   (lane_err[gi]),
                .ap_q  (s1_ap_reg[COEFF_W*gi +: COEFF_W]),
                .sum_q (s1_sum_reg[COEFF_W*gi +: COEFF_W]),
                .a1    (lane_a1[COEFF_W*gi +: COEFF_W]),
                .a0    (lane_a0[COEFF_W*gi +: COEFF_W])
            );
        end
    endgenerate

    // Stage 2 moves whenever it is empty or its beat is being taken; stage 1
    // therefore sees out_ready combinationally, which is what allows full
    // throughput under continuous backpressure release.
    assign s2_adv    = !out_valid || out_ready;
    assign in_ready  = !s1_valid_reg || s2_adv;
    assign in_fire   = in_valid && in_ready;
    assign beat_last = (beat_reg == BW'(NB - 1));
    assign poly_last = (poly_reg == PW'(K - 1));
    assign busy      = busy_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_reg <= '0;
            poly_reg <= '0;
        end else if (in_fire) begin
            if (beat_last) begin
                beat_reg <= '0;
                poly_reg <= poly_last ? '0 : (poly_reg + PW'(1));
            end else begin
                beat_reg <= beat_reg + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg     <= 1'b0;
            s1_ap_reg        <= '0;
            s1_sum_reg       <= '0;
            s1_err_reg       <= '0;
            s1_poly_reg      <= '0;
            s1_last_poly_reg <= 1'b0;
            s1_last_reg      <= 1'b0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_ap_reg        <= lane_ap;
                s1_sum_reg       <= lane_sum;
                s1_err_reg       <= lane_err;
                s1_poly_reg      <= poly_reg;
                s1_last_poly_reg <= beat_last;
                s1_last_reg      <= beat_last && poly_last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_a1        <= '0;
            out_a0        <= '0;
            out_poly      <= '0;
            out_last_poly <= 1'b0;
            out_last      <= 1'b0;
            out_range_err <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_a1        <= lane_a1;
                out_a0        <= lane_a0;
                out_poly      <= s1_poly_reg;
                out_last_poly <= s1_last_poly_reg;
                out_last      <= s1_last_reg;
                out_range_err <= |s1_err_reg;
            end
        end
    end

    // A new vector starting on the same cycle its predecessor's out_last is
    // taken must leave busy set, so the start condition has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= 1'b0;
        end else if (in_fire && (beat_reg == '0) && (poly_reg == '0)) begin
            busy_reg <= 1'b1;
        end else if (out_valid && out_ready && out_last) begin
            busy_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_polyveck_power2round_stream.sv
// -----------------------------------------------------------------------------
// tb_polyveck_power2round_stream
// Bench for the streaming Power2Round: a K=6/N=256/LANES=8 instance with
// CADDQ_EN=1 and a K=1/N=8 instance with CADDQ_EN=0. Expected values come from
// a centred-remainder reference model of Power2Round plus position arithmetic.
// -----------------------------------------------------------------------------
module tb_polyveck_power2round_stream;

    localparam int K     = 6;
    localparam int N     = 256;
    localparam int LANES = 8;
    localparam int Q     = 8380417;
    localparam int NB    = N / LANES;
    localparam int VB    = K * NB;
    localparam int W     = 32 * LANES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data  = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_a1;
    logic [W-1:0] out_a0;
    logic [2:0]   out_poly;
    logic         out_last_poly;
    logic         out_last;
    logic         out_range_err;
    logic         busy;

    // K=1, CADDQ_EN=0 instance
    logic         z_in_valid = 1'b0;
    logic         z_in_ready;
    logic [W-1:0] z_in_data  = '0;
    logic         z_out_valid;
    logic         z_out_ready = 1'b1;
    logic [W-1:0] z_out_a1;
    logic [W-1:0] z_out_a0;
    logic [0:0]   z_out_poly;
    logic         z_out_last_poly;
    logic         z_out_last;
    logic         z_out_range_err;
    logic         z_busy;

    polyveck_power2round_stream #(.K(K), .N(N), .LANES(LANES), .CADDQ_EN(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a1(out_a1), .out_a0(out_a0), .out_poly(out_poly),
        .out_last_poly(out_last_poly), .out_last(out_last),
        .out_range_err(out_range_err), .busy(busy)
    );

    polyveck_power2round_stream #(.K(1), .N(8), .LANES(LANES), .CADDQ_EN(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
        .out_valid(z_out_valid), .out_ready(z_out_ready),
        .out_a1(z_out_a1), .out_a0(z_out_a0), .out_poly(z_out_poly),
        .out_last_poly(z_out_last_poly), .out_last(z_out_last),
        .out_range_err(z_out_range_err), .busy(z_busy)
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] stim [0:2*VB-1];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Power2Round as a centred remainder: a0 = a' mod 2^13 mapped into
    // (-4096, 4096], a1 = (a' - a0) / 2^13.
    function automatic void ref_beat(input logic [W-1:0] x, input bit caddq,
                                     output logic [W-1:0] a1, output logic [W-1:0] a0,
                                     output logic err);
        a1  = '0;
        a0  = '0;
        err = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            logic [31:0] v;
            longint a, ap, m, r0, r1;
            v  = x[32*i +: 32];
            a  = longint'($signed(v));
            ap = (caddq && a < 0) ? a + Q : a;
            m  = ((ap % 8192) + 8192) % 8192;
            r0 = (m > 4096) ? m - 8192 : m;
            r1 = (ap - r0) / 8192;
            a1[32*i +: 32] = r1[31:0];
            a0[32*i +: 32] = r0[31:0];
            if (ap < 0 || ap >= Q) err = 1'b1;
        end
    endfunction

    function automatic logic [W-1:0] splat(input logic [31:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[32*i +: 32] = v;
        return r;
    endfunction

    // Streams stim[0..nin-1] into the main instance and checks every output
    // beat against the model; optional stalls and an optional reset after
    // abort_at accepted beats.
    task automatic run_stream(input int nin, input bit stall, input int abort_at);
        int sent = 0, got = 0, cyc = 0;
        int first_acc = -1, first_out = -1, prev_acc = -1;
        bit prev_stall = 1'b0;
        logic [W-1:0] sv_a1 = '0, sv_a0 = '0, e_a1, e_a0;
        logic [7:0] sv_meta = '0, meta;
        logic e_err;
        int idx;
        while (got < nin && cyc < 4000) begin
            @(negedge clk);
            meta = {1'b0, out_valid, out_poly, out_last_poly, out_last, out_range_err};
            if (prev_stall) begin
                chk("stall_a1", out_a1, sv_a1);
                chk("stall_a0", out_a0, sv_a0);
                chk("stall_meta", W'(meta), W'(sv_meta));
            end
            if (abort_at >= 0 && sent == abort_at) begin
                in_valid = 1'b0;
                rst = 1'b1;
                #1;
                chk("abort_out_valid", W'(out_valid), W'(0));
                chk("abort_busy", W'(busy), W'(0));
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < nin && (!stall || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                in_data  = stim[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                idx = got % VB;
                ref_beat(stim[got], 1'b1, e_a1, e_a0, e_err);
                chk("a1", out_a1, e_a1);
                chk("a0", out_a0, e_a0);
                chk("range_err", W'(out_range_err), W'(e_err));
                chk("position", W'({out_poly, out_last_poly, out_last}),
                    W'({3'(idx / NB), (idx % NB) == NB - 1, idx == VB - 1}));
                if (got == 0) chk("busy_run", W'(busy), W'(1));
                if (first_out < 0) first_out = cyc;
                got++;
            end
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                if (!stall && prev_acc >= 0) chk("accept_gap", W'(cyc - prev_acc), W'(1));
                prev_acc = cyc;
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            sv_a1   = out_a1;
            sv_a0   = out_a0;
            sv_meta = {1'b0, out_valid, out_poly, out_last_poly, out_last, out_range_err};
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("beats_out", W'(got), W'(nin));
        if (!stall) chk("latency", W'(first_out - first_acc), W'(2));
        @(negedge clk);
        #1;
        chk("busy_after", W'(busy), W'(0));
        chk("idle_valid", W'(out_valid), W'(0));
    endtask

    initial begin
        logic [W-1:0] beat_a, exp_a1, exp_a0;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_a1", out_a1, '0);
        chk("rst_a0", out_a0, '0);
        chk("rst_meta", W'({out_poly, out_last_poly, out_last, out_range_err, busy}), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_z_meta", W'({z_out_valid, z_out_poly, z_out_last, z_busy}), W'(0));

        // Boundary values, lane 0 first: 0, 4096, 4097, 8380416, -1, -1, 0, 0
        beat_a = {32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'd8380416, 32'd4097, 32'd4096, 32'd0};
        exp_a1 = {32'd0, 32'd0, 32'd1023, 32'd1023, 32'd1023, 32'd1, 32'd0, 32'd0};
        exp_a0 = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_F001, 32'd4096, 32'd0};
        @(negedge clk);
        in_data = beat_a;  in_valid = 1'b1;
        z_in_data = splat(32'hFFFF_FFFF);  z_in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;  z_in_valid = 1'b0;
        #1;
        chk("lat_not_yet", W'(out_valid), W'(0));
        @(negedge clk);
        #1;
        chk("bnd_valid", W'(out_valid), W'(1));
        chk("bnd_a1", out_a1, exp_a1);
        chk("bnd_a0", out_a0, exp_a0);
        chk("bnd_err", W'(out_range_err), W'(0));
        chk("bnd_busy", W'(busy), W'(1));
        chk("neg_nocaddq_a1", z_out_a1, '0);
        chk("neg_nocaddq_a0", z_out_a0, splat(32'hFFFF_FFFF));
        chk("neg_nocaddq_err", W'(z_out_range_err), W'(1));
        chk("k1_tags", W'({z_out_valid, z_out_poly, z_out_last_poly, z_out_last, z_busy}),
            W'(5'b10111));

        // Input Q: out of range in both modes, a1=1023, a0=1
        @(negedge clk);
        in_data = splat(32'd8380417);  in_valid = 1'b1;
        z_in_data = splat(32'd8380417);  z_in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;  z_in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("q_err", W'(out_range_err), W'(1));
        chk("q_a1", out_a1, splat(32'd1023));
        chk("q_a0", out_a0, splat(32'd1));
        chk("q_z_err", W'(z_out_range_err), W'(1));
        chk("q_z_a1", z_out_a1, splat(32'd1023));

        // Abandon the partial vector via reset
        @(negedge clk);
        chk("busy_before_rst", W'(busy), W'(1));
        rst = 1'b1;
        #1;
        chk("rst_busy", W'(busy), W'(0));
        @(negedge clk);
        rst = 1'b0;

        // Full vector, no stall, then the same data with random stalls
        for (int b = 0; b < 2 * VB; b++)
            for (int l = 0; l < LANES; l++)
                stim[b][32*l +: 32] = $urandom_range(0, Q - 1);
        run_stream(VB, 1'b0, -1);
        run_stream(VB, 1'b1, -1);

        // Two vectors back to back
        for (int b = 0; b < 2 * VB; b++)
            for (int l = 0; l < LANES; l++)
                stim[b][32*l +: 32] = $urandom_range(0, Q - 1);
        run_stream(2 * VB, 1'b0, -1);

        // Reset after 70 beats, then a clean vector
        run_stream(VB, 1'b0, 70);
        #1;
        chk("post_abort_valid", W'(out_valid), W'(0));
        run_stream(VB, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
